// File: rtl/exec_s4_muldiv.sv
// Stage-4 execute block: single-cycle ALU plus an iterative multiply/divide
// unit (shift-add multiply, restoring divide, one bit per cycle). While the
// multiply/divide unit is working, stall holds the upstream latches and a
// bubble (zero flags, zero result) is sent to stage 5.
module exec_s4_muldiv #(
  parameter int XLEN      = 32,  // datapath width; only 32 is supported
  parameter int MD_CYCLES = 32   // iterations per multiply/divide; equals XLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic [4:0]      rd_in,
  input  logic [XLEN-1:0] rs1_data_in,
  input  logic [XLEN-1:0] rs2_data_in,
  input  logic [XLEN-1:0] imm_in,
  input  logic [15:0]     instr_flags_in,
  output logic [XLEN-1:0] result_out,
  output logic [XLEN-1:0] store_data_out,
  output logic [4:0]      rd_out,
  output logic [15:0]     instr_flags_out,
  output logic            stall,
  output logic            md_busy
);

  localparam int                CNT_W    = $clog2(MD_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(MD_CYCLES - 1);
  localparam logic [XLEN-1:0]   X_ZERO   = {XLEN{1'b0}};
  localparam logic [XLEN-1:0]   X_ONES   = {XLEN{1'b1}};
  localparam logic [XLEN:0]     XP_ZERO  = {(XLEN+1){1'b0}};

  // ALU opcodes
  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SLL  = 4'd5;
  localparam logic [3:0] OP_SRL  = 4'd6;
  localparam logic [3:0] OP_SRA  = 4'd7;
  localparam logic [3:0] OP_SLT  = 4'd8;
  localparam logic [3:0] OP_SLTU = 4'd9;
  localparam logic [3:0] OP_PASS = 4'd10;

  // Multiply/divide sub-opcodes
  localparam logic [1:0] MD_MUL   = 2'b00;
  localparam logic [1:0] MD_MULHU = 2'b01;
  localparam logic [1:0] MD_DIVU  = 2'b10;
  localparam logic [1:0] MD_REMU  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Registers
  state_e              state_q;
  logic [CNT_W-1:0]    count_q;
  logic [XLEN-1:0]     a_q;
  logic [XLEN-1:0]     b_q;
  logic [1:0]          op_q;
  // Multiply: {partial product high, multiplier/low product}.
  // Divide:   {partial remainder, dividend/quotient}.
  logic [2*XLEN-1:0]   acc_q;
  logic [2*XLEN-1:0]   acc_d;

  // Decoded flag fields
  logic [3:0]          alu_op_s;
  logic                use_imm_s;
  logic                is_md_s;
  logic [1:0]          md_op_s;
  logic [XLEN-1:0]     alu_b_s;
  logic [4:0]          shamt_s;
  logic [XLEN-1:0]     alu_res_s;
  logic [XLEN-1:0]     md_res_s;
  logic                md_start_s;
  logic                stall_s;
  logic                b_zero_s;

  // Iteration datapath
  logic [XLEN:0]       mul_sum_s;
  logic [XLEN:0]       div_rem_sh_s;
  logic [XLEN:0]       div_diff_s;

  assign alu_op_s  = instr_flags_in[3:0];
  assign use_imm_s = instr_flags_in[4];
  assign is_md_s   = instr_flags_in[8];
  assign md_op_s   = instr_flags_in[10:9];
  assign alu_b_s   = use_imm_s ? imm_in : rs2_data_in;
  assign shamt_s   = alu_b_s[4:0];
  assign b_zero_s  = (b_q == X_ZERO);

  // A new multiply/divide starts only from IDLE; flush and reset both
  // suppress the start, since neither cycle can capture the operands.
  assign md_start_s = (state_q == ST_IDLE) && is_md_s && !flush && !rst;
  assign stall_s    = !flush && !rst && (md_start_s || (state_q == ST_BUSY));

  assign stall          = stall_s;
  assign md_busy        = (state_q == ST_BUSY);
  assign rd_out         = rd_in;
  assign store_data_out = rs2_data_in;

  // Single-cycle ALU for non-multiply/divide instructions
  always_comb begin
    alu_res_s = X_ZERO;
    case (alu_op_s)
      OP_ADD:  alu_res_s = rs1_data_in + alu_b_s;
      OP_SUB:  alu_res_s = rs1_data_in - alu_b_s;
      OP_AND:  alu_res_s = rs1_data_in & alu_b_s;
      OP_OR:   alu_res_s = rs1_data_in | alu_b_s;
      OP_XOR:  alu_res_s = rs1_data_in ^ alu_b_s;
      OP_SLL:  alu_res_s = rs1_data_in << shamt_s;
      OP_SRL:  alu_res_s = rs1_data_in >> shamt_s;
      OP_SRA:  alu_res_s = $unsigned($signed(rs1_data_in) >>> shamt_s);
      OP_SLT:  alu_res_s = ($signed(rs1_data_in) < $signed(alu_b_s)) ?
                           {{(XLEN-1){1'b0}}, 1'b1} : X_ZERO;
      OP_SLTU: alu_res_s = (rs1_data_in < alu_b_s) ?
                           {{(XLEN-1){1'b0}}, 1'b1} : X_ZERO;
      OP_PASS: alu_res_s = alu_b_s;
      default: alu_res_s = X_ZERO;
    endcase
  end

  // One multiply (shift-add) or restoring-divide step on the accumulator
  always_comb begin
    mul_sum_s    = {1'b0, acc_q[2*XLEN-1:XLEN]} +
                   (acc_q[0] ? {1'b0, b_q} : XP_ZERO);
    div_rem_sh_s = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    div_diff_s   = div_rem_sh_s - {1'b0, b_q};
    if (op_q[1]) begin
      // Divide: keep the difference only when it did not borrow
      if (!div_diff_s[XLEN]) begin
        acc_d = {div_diff_s[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
      end else begin
        acc_d = {div_rem_sh_s[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
      end
    end else begin
      // Multiply: add multiplicand on a set multiplier bit, then shift right
      acc_d = {mul_sum_s, acc_q[XLEN-1:1]};
    end
  end

  // Final multiply/divide result, with the divide-by-zero overrides
  always_comb begin
    md_res_s = X_ZERO;
    case (op_q)
      MD_MUL:   md_res_s = acc_q[XLEN-1:0];
      MD_MULHU: md_res_s = acc_q[2*XLEN-1:XLEN];
      MD_DIVU:  md_res_s = b_zero_s ? X_ONES : acc_q[XLEN-1:0];
      MD_REMU:  md_res_s = b_zero_s ? a_q : acc_q[2*XLEN-1:XLEN];
      default:  md_res_s = X_ZERO;
    endcase
  end

  // Output mux: bubble while stalled, md result in DONE, else ALU result
  always_comb begin
    result_out      = X_ZERO;
    instr_flags_out = 16'h0000;
    if (stall_s) begin
      result_out      = X_ZERO;
      instr_flags_out = 16'h0000;
    end else if (state_q == ST_DONE) begin
      result_out      = md_res_s;
      instr_flags_out = instr_flags_in;
    end else begin
      result_out      = alu_res_s;
      instr_flags_out = instr_flags_in;
    end
  end

  // Multiply/divide control FSM with its operand and accumulator registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      count_q <= CNT_ZERO;
      a_q     <= X_ZERO;
      b_q     <= X_ZERO;
      op_q    <= 2'b00;
      acc_q   <= {X_ZERO, X_ZERO};
    end else if (flush) begin
      state_q <= ST_IDLE;
      count_q <= CNT_ZERO;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (md_start_s) begin
            a_q     <= rs1_data_in;
            b_q     <= rs2_data_in;
            op_q    <= md_op_s;
            acc_q   <= {X_ZERO, rs1_data_in};
            count_q <= CNT_ZERO;
            state_q <= ST_BUSY;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_BUSY: begin
          acc_q   <= acc_d;
          count_q <= count_q + CNT_ONE;
          if (count_q == CNT_LAST) begin
            state_q <= ST_DONE;
          end else begin
            state_q <= ST_BUSY;
          end
        end
        ST_DONE: begin
          // Upstream latch advances at the end of this cycle, so no restart
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
          count_q <= CNT_ZERO;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_exec_s4_muldiv.sv
// Directed, table-driven bench for exec_s4_muldiv.
module tb_exec_s4_muldiv;

  logic        clk;
  logic        rst;
  logic        flush;
  logic [4:0]  rd_in;
  logic [31:0] rs1_data_in;
  logic [31:0] rs2_data_in;
  logic [31:0] imm_in;
  logic [15:0] instr_flags_in;
  logic [31:0] result_out;
  logic [31:0] store_data_out;
  logic [4:0]  rd_out;
  logic [15:0] instr_flags_out;
  logic        stall;
  logic        md_busy;

  int checks = 0;
  int errors = 0;

  exec_s4_muldiv #(.XLEN(32), .MD_CYCLES(32)) dut (
    .clk             (clk),
    .rst             (rst),
    .flush           (flush),
    .rd_in           (rd_in),
    .rs1_data_in     (rs1_data_in),
    .rs2_data_in     (rs2_data_in),
    .imm_in          (imm_in),
    .instr_flags_in  (instr_flags_in),
    .result_out      (result_out),
    .store_data_out  (store_data_out),
    .rd_out          (rd_out),
    .instr_flags_out (instr_flags_out),
    .stall           (stall),
    .md_busy         (md_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
    logic [15:0] flags;
    logic [31:0] exp;
  } alu_vec_t;

  alu_vec_t vecs [15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] alu_f(input logic [3:0] op, input logic use_imm);
    return {11'd0, use_imm, op} | 16'h0020;
  endfunction

  function automatic logic [15:0] md_f(input logic [1:0] op);
    return 16'h0120 | {5'd0, op, 9'd0};
  endfunction

  function automatic alu_vec_t mk(input string n, input logic [31:0] a, input logic [31:0] b,
                                  input logic [31:0] imm, input logic [15:0] f,
                                  input logic [31:0] e);
    alu_vec_t v;
    v.name = n; v.a = a; v.b = b; v.imm = imm; v.flags = f; v.exp = e;
    return v;
  endfunction

  // Issue one multiply/divide and check stall length, bubble and result
  task automatic run_md(input string name, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp);
    int stall_cnt;
    int busy_cnt;
    bit done;
    @(negedge clk);
    rd_in = 5'd17; rs1_data_in = a; rs2_data_in = b; imm_in = 32'h0000_0000;
    instr_flags_in = md_f(op);
    #1;
    chk({name, "_start_stall"}, {31'd0, stall}, 32'd1);
    chk({name, "_bubble_flags"}, {16'd0, instr_flags_out}, 32'd0);
    chk({name, "_bubble_result"}, result_out, 32'd0);
    chk({name, "_rd_pass"}, {27'd0, rd_out}, 32'd17);
    stall_cnt = 1;
    busy_cnt  = int'(md_busy);
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      #1;
      if (!stall) begin
        done = 1'b1;
      end else begin
        stall_cnt++;
        busy_cnt += int'(md_busy);
      end
    end
    chk({name, "_completed"}, {31'd0, done}, 32'd1);
    chk({name, "_stall_cycles"}, stall_cnt, 32'd33);
    chk({name, "_busy_cycles"}, busy_cnt, 32'd32);
    chk({name, "_result"}, result_out, exp);
    chk({name, "_done_flags"}, {16'd0, instr_flags_out}, {16'd0, md_f(op)});
    chk({name, "_done_busy"}, {31'd0, md_busy}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; rd_in = 5'd0; rs1_data_in = 32'd0; rs2_data_in = 32'd0;
    imm_in = 32'd0; instr_flags_in = 16'd0;

    vecs[0]  = mk("add_imm",   32'd5,         32'd0,  32'hFFFF_FFFE, alu_f(4'd0, 1'b1), 32'd3);
    vecs[1]  = mk("sub",       32'd3,         32'd5,  32'd0,         alu_f(4'd1, 1'b0), 32'hFFFF_FFFE);
    vecs[2]  = mk("and",       32'h0000_F0F0, 32'h0000_FF00, 32'd0,  alu_f(4'd2, 1'b0), 32'h0000_F000);
    vecs[3]  = mk("or",        32'h0000_F0F0, 32'h0000_FF00, 32'd0,  alu_f(4'd3, 1'b0), 32'h0000_FFF0);
    vecs[4]  = mk("xor",       32'h0000_F0F0, 32'h0000_FF00, 32'd0,  alu_f(4'd4, 1'b0), 32'h0000_0FF0);
    vecs[5]  = mk("sll31",     32'd1,         32'd31, 32'd0,         alu_f(4'd5, 1'b0), 32'h8000_0000);
    vecs[6]  = mk("sll_mask",  32'd1,         32'd33, 32'd0,         alu_f(4'd5, 1'b0), 32'd2);
    vecs[7]  = mk("srl",       32'h8000_0000, 32'd4,  32'd0,         alu_f(4'd6, 1'b0), 32'h0800_0000);
    vecs[8]  = mk("sra",       32'h8000_0000, 32'd4,  32'd0,         alu_f(4'd7, 1'b0), 32'hF800_0000);
    vecs[9]  = mk("slt",       32'hFFFF_FFFF, 32'd1,  32'd0,         alu_f(4'd8, 1'b0), 32'd1);
    vecs[10] = mk("sltu",      32'hFFFF_FFFF, 32'd1,  32'd0,         alu_f(4'd9, 1'b0), 32'd0);
    vecs[11] = mk("pass_imm",  32'd7,         32'd9,  32'h1234_5678, alu_f(4'd10, 1'b1), 32'h1234_5678);
    vecs[12] = mk("op12_zero", 32'd7,         32'd9,  32'd0,         alu_f(4'd12, 1'b0), 32'd0);
    vecs[13] = mk("add_wrap",  32'hFFFF_FFFF, 32'd1,  32'd0,         alu_f(4'd0, 1'b0), 32'd0);
    vecs[14] = mk("rsvd_pass", 32'd10,        32'd20, 32'd0,         alu_f(4'd0, 1'b0) | 16'hF800, 32'd30);

    // Reset state with all inputs zero
    @(negedge clk);
    #1;
    chk("rst_result", result_out, 32'd0);
    chk("rst_flags", {16'd0, instr_flags_out}, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_busy", {31'd0, md_busy}, 32'd0);
    chk("rst_store", store_data_out, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Table-driven ALU vectors
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      rd_in = 5'(i + 1); rs1_data_in = vecs[i].a; rs2_data_in = vecs[i].b;
      imm_in = vecs[i].imm; instr_flags_in = vecs[i].flags;
      #1;
      chk(vecs[i].name, result_out, vecs[i].exp);
      chk({vecs[i].name, "_stall"}, {31'd0, stall}, 32'd0);
      chk({vecs[i].name, "_flags"}, {16'd0, instr_flags_out}, {16'd0, vecs[i].flags});
      chk({vecs[i].name, "_rd"}, {27'd0, rd_out}, 32'(i + 1));
      chk({vecs[i].name, "_store"}, store_data_out, vecs[i].b);
    end

    // Multiply/divide, back-to-back
    run_md("mul",        2'b00, 32'hFFFF_FFFF, 32'd2,    32'hFFFF_FFFE);
    run_md("mulhu",      2'b01, 32'hFFFF_FFFF, 32'd2,    32'h0000_0001);
    run_md("mul_big",    2'b00, 32'h1234_5678, 32'h10,   32'h2345_6780);
    run_md("divu",       2'b10, 32'd100,       32'd7,    32'd14);
    run_md("remu",       2'b11, 32'd100,       32'd7,    32'd2);
    run_md("divu_big",   2'b10, 32'hFFFF_FFFF, 32'h10,   32'h0FFF_FFFF);
    run_md("remu_big",   2'b11, 32'hFFFF_FFFF, 32'h10,   32'h0000_000F);
    run_md("divu_zero",  2'b10, 32'd100,       32'd0,    32'hFFFF_FFFF);
    run_md("remu_zero",  2'b11, 32'd100,       32'd0,    32'd100);

    // Flush during BUSY cycle 10
    @(negedge clk);
    rs1_data_in = 32'hFFFF_FFFF; rs2_data_in = 32'd2; instr_flags_in = md_f(2'b00);
    repeat (10) @(negedge clk);
    flush = 1'b1;
    #1;
    chk("flush_stall", {31'd0, stall}, 32'd0);
    chk("flush_busy_still", {31'd0, md_busy}, 32'd1);
    @(negedge clk);
    flush = 1'b0; rs1_data_in = 32'd1; rs2_data_in = 32'd2; instr_flags_in = alu_f(4'd0, 1'b0);
    #1;
    chk("flush_busy_next", {31'd0, md_busy}, 32'd0);
    chk("flush_alu_stall", {31'd0, stall}, 32'd0);
    chk("flush_alu_result", result_out, 32'd3);

    // Asynchronous reset between edges during BUSY
    @(negedge clk);
    rs1_data_in = 32'd100; rs2_data_in = 32'd7; instr_flags_in = md_f(2'b10);
    repeat (5) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_stall", {31'd0, stall}, 32'd0);
    chk("arst_busy", {31'd0, md_busy}, 32'd0);
    @(negedge clk);
    instr_flags_in = 16'd0;
    rst = 1'b0;
    run_md("divu_after_rst", 2'b10, 32'd100, 32'd7, 32'd14);

    @(negedge clk);
    instr_flags_in = 16'd0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/exec_s4_muldiv.md
Name: exec_s4_muldiv

Overview:
- Stage-4 execute block; consumes the stage-3/stage-4 pipeline latch outputs and feeds the stage-4/stage-5 latch.
- Single-cycle ALU for ordinary ops.
- Iterative 32-cycle multiply/divide unit for MUL/MULHU/DIVU/REMU.
- Raises `stall` while the multiply/divide unit is iterating, so the upstream latches hold (their `enable` is driven low).

Parameters:
- XLEN, 32, datapath width; only 32 is supported.
- MD_CYCLES, 32, iterations per multiply/divide; must equal XLEN.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous reset, active-high.
- flush  input  1  synchronous abort of any in-flight multiply/divide.
- rd_in  input  5  destination register from the latch.
- rs1_data_in  input  32  operand A.
- rs2_data_in  input  32  operand B register value.
- imm_in  input  32  immediate.
- instr_flags_in  input  16  control flags; 0 denotes a bubble.
- result_out  output  32  execute result.
- store_data_out  output  32  equals rs2_data_in, for stores.
- rd_out  output  5  equals rd_in.
- instr_flags_out  output  16  equals instr_flags_in; forced to 0 while stall=1.
- stall  output  1  hold upstream latches, insert bubble downstream.
- md_busy  output  1  state==BUSY.

Behaviour:
Flag fields:
- [3:0] alu_op; [4] use_imm (B=imm_in, else B=rs2_data_in); [5] reg_write; [6] mem_read; [7] mem_write; [8] is_md; [10:9] md_op; [15:11] reserved, passed through unchanged.

ALU (combinational, used when is_md=0):
- alu_op 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR.
- 5 SLL, 6 SRL, 7 SRA; shift amount is B[4:0].
- 8 SLT (signed), 9 SLTU.
- 10 PASS_B.
- 11-15 produce 0.
- Arithmetic wraps modulo 2^32.

Multiply/divide:
- md_op 00 MUL (low 32 bits of the 64-bit product), 01 MULHU (high 32 bits, unsigned), 10 DIVU, 11 REMU.
- Operand B is always rs2_data_in.
- Multiply is shift-add; divide is restoring, one bit per cycle.
- Divide by zero: DIVU result = 0xFFFFFFFF, REMU result = A. The divisor is still iterated and the result is selected in DONE.

FSM, registered (states IDLE, BUSY, DONE):
- IDLE:
  - If is_md=1 and flush=0: latch A/B/md_op, count<=0, go to BUSY. stall=1 combinationally in this cycle.
  - Otherwise: stall=0 and result_out = ALU result.
- BUSY:
  - stall=1; one iteration per cycle; count increments.
  - When count==MD_CYCLES-1, go to DONE.
- DONE:
  - stall=0; result_out = md result.
  - Next state is IDLE unconditionally.
  - The upstream latch advances at the end of this cycle, so the same instruction is not restarted.
- Latency: an MD instruction entering in cycle T asserts stall for cycles T..T+32 (33 cycles). Its result is valid in cycle T+33.
- While stall=1: instr_flags_out=0 and result_out=0 (bubble to stage 5). rd_out and store_data_out pass through.
- flush=1 in any state: next state IDLE, count<=0. stall is 0 in the flush cycle. The IDLE start condition is suppressed when flush=1.

Reset (rst=1, asynchronous):
- state=IDLE, count=0, internal operand/accumulator registers=0.
- Outputs follow inputs: with zero inputs, all outputs are 0 and stall=0, md_busy=0.
- Reset mid-BUSY discards the operation immediately.

Test Plan:
- ADD imm path: A=5, imm=0xFFFFFFFE, flags use_imm=1, alu_op=0 -> result_out=3 in the same cycle, stall=0.
- SRA: A=0x80000000, B=4, alu_op=7 -> result_out=0xF8000000. SLT with A=-1, B=1 -> 1; SLTU with the same operands -> 0.
- MUL/MULHU: A=0xFFFFFFFF, B=2 -> stall high for exactly 33 cycles, md_busy high for 32 cycles. MUL gives 0xFFFFFFFE; MULHU gives 0x00000001 in the DONE cycle.
- DIVU/REMU: A=100, B=7 -> 14 / 2. With B=0: DIVU -> 0xFFFFFFFF, REMU -> 100. Back-to-back MD instructions each stall 33 cycles with no restart of the first.
- flush at BUSY cycle 10 -> stall=0 in the flush cycle, md_busy=0 next cycle; a following ALU op executes normally.
- rst asserted mid-BUSY, asynchronously between clock edges -> stall and md_busy drop immediately. After release, a new DIVU completes with the correct result.
